// File: rtl/bcd_chain_ctrl.sv
// Run/pause/idle sequencer, count-rate prescaler and ripple-carry enables
// for a chain of NDIG cascaded BCD digits.
module bcd_chain_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000000,
    parameter int PW       = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] digits,
    output logic              running,
    output logic              tick,
    output logic              wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;

    logic              advance;
    logic              all_nine;
    logic [NDIG-1:0]   en;
    logic [4*NDIG-1:0] load_fix;

    always_comb begin
        load_fix = '0;
        all_nine = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            // Out-of-range preset nibbles become 0 so 10-15 never enter the chain.
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_fix[4*i +: 4] = load_val[4*i +: 4];
            end
            if (digits_q[4*i +: 4] != 4'd9) begin
                all_nine = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        digits_d = digits_q;
        advance  = 1'b0;
        if (clear) begin
            state_d  = S_IDLE;
            pre_d    = '0;
            digits_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pre_d = '0;
                    if (load) begin
                        digits_d = load_fix;
                    end else if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (pre_q == PRE_MAX) begin
                        pre_d   = '0;
                        advance = 1'b1;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (load) begin
                        digits_d = load_fix;
                    end else if (start) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Single-cycle carry chain: every digit updates on the same edge.
        en[0] = advance;
        for (int i = 1; i < NDIG; i++) begin
            en[i] = en[i-1] & (digits_q[4*(i-1) +: 4] == 4'd9);
        end
        for (int i = 0; i < NDIG; i++) begin
            if (en[i]) begin
                digits_d[4*i +: 4] = (digits_q[4*i +: 4] == 4'd9) ?
                                     4'd0 : digits_q[4*i +: 4] + 4'd1;
            end
        end

        tick_d = advance;
        wrap_d = advance & all_nine;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            digits_q <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            digits_q <= digits_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign digits  = digits_q;
    assign running = (state_q == S_RUN);
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Bench for bcd_chain_ctrl: two configurations driven in lockstep and
// compared every cycle against an integer-count reference model.
module tb_bcd_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] dig_a;
    logic       run_a, tick_a, wrap_a;
    logic [3:0] dig_b;
    logic       run_b, tick_b, wrap_b;

    bcd_chain_ctrl #(.NDIG(2), .PRESCALE(3), .PW(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val),
        .digits(dig_a), .running(run_a), .tick(tick_a), .wrap(wrap_a)
    );

    bcd_chain_ctrl #(.NDIG(1), .PRESCALE(1), .PW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val[3:0]),
        .digits(dig_b), .running(run_b), .tick(tick_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: 0=idle 1=run 2=pause; count held as a plain integer.
    int st[2];
    int cnt[2];
    int pre[2];
    int tk[2];
    int wr[2];
    int nd[2] = '{2, 1};
    int ps[2] = '{3, 1};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int load_num(input int m);
        int v = 0;
        int mul = 1;
        for (int i = 0; i < nd[m]; i++) begin
            int d;
            d = int'(load_val[4*i +: 4]);
            if (d > 9) d = 0;
            v += d * mul;
            mul *= 10;
        end
        return v;
    endfunction

    function automatic int to_bcd(input int v, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) begin
            r |= (v % 10) << (4 * i);
            v /= 10;
        end
        return r;
    endfunction

    task automatic model(input int m);
        int modv = 1;
        int adv = 0;
        for (int i = 0; i < nd[m]; i++) modv *= 10;
        if (!rst_n) begin
            st[m] = 0; cnt[m] = 0; pre[m] = 0; tk[m] = 0; wr[m] = 0;
            return;
        end
        if (clear) begin
            st[m] = 0; cnt[m] = 0; pre[m] = 0;
        end else if (st[m] == 0) begin
            if (load) cnt[m] = load_num(m);
            else if (start) begin st[m] = 1; pre[m] = 0; end
        end else if (st[m] == 1) begin
            if (stop) st[m] = 2;
            else if (pre[m] == ps[m] - 1) begin pre[m] = 0; adv = 1; end
            else pre[m]++;
        end else begin
            if (load) cnt[m] = load_num(m);
            else if (start) st[m] = 1;
        end
        wr[m] = (adv == 1 && cnt[m] == modv - 1) ? 1 : 0;
        if (adv == 1) cnt[m] = (cnt[m] + 1) % modv;
        tk[m] = adv;
    endtask

    task automatic step();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        check("dig_a", int'(dig_a), to_bcd(cnt[0], 2));
        check("run_a", int'(run_a), (st[0] == 1) ? 1 : 0);
        check("tick_a", int'(tick_a), tk[0]);
        check("wrap_a", int'(wrap_a), wr[0]);
        check("dig_b", int'(dig_b), to_bcd(cnt[1], 1));
        check("run_b", int'(run_b), (st[1] == 1) ? 1 : 0);
        check("tick_b", int'(tick_b), tk[1]);
        check("wrap_b", int'(wrap_b), wr[1]);
    endtask

    task automatic drive(input logic s, input logic p, input logic c,
                         input logic l, input logic [7:0] v);
        start = s; stop = p; clear = c; load = l; load_val = v;
    endtask

    initial begin
        // Reset with start held.
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 8'h00);
        step();
        rst_n = 1'b1;

        // Count 00..10 through the first carry.
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (30) step();

        // Preset 98 and run through the all-nine wrap.
        drive(0, 0, 1, 0, 8'h00); step();
        drive(0, 0, 0, 1, 8'h98); step();
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (9) step();

        // Stop mid-period, hold pause, resume with retained prescaler.
        drive(0, 0, 1, 0, 8'h00); step();
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00); step();
        drive(0, 1, 0, 0, 8'h00);
        repeat (10) step();
        drive(1, 1, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (4) step();

        // clear + start + load in RUN.
        drive(0, 0, 1, 1, 8'h55); start = 1'b1; step();
        drive(0, 0, 0, 0, 8'h00); step();

        // Invalid nibble in a PAUSE load.
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 1, 0, 0, 8'h00); step();
        drive(0, 0, 0, 1, 8'hA7); step();
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (12) step();

        // Randomized control mix, including occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            clear    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 5);
            stop     = ($urandom_range(0, 99) < 6);
            start    = ($urandom_range(0, 99) < 15);
            load_val = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
